// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: strobes one row at a time, debounces whole-frame results
// and turns accepted presses into hex key codes plus an 8-digit entry register.
//
// state   | meaning
// IDLE    | no key held, waiting for a frame with exactly one contact
// CONFIRM | candidate latched, counting matching frames in fc
// HELD    | press accepted, key_held high, further keys ignored
// RELEASE | counting empty frames in fc before dropping key_held
module keypad_scan #(
    parameter int SCAN_BITS = 15,
    parameter int DEBOUNCE  = 3
) (
    input  logic        cclk,
    input  logic        rst,
    output logic [3:0]  row,
    input  logic [3:0]  col,
    output logic [3:0]  key,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] val
);

    localparam int         CW = SCAN_BITS + 2;
    localparam logic [2:0] DB = 3'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

    function automatic logic [31:0] entry_next(input logic [31:0] v, input logic [3:0] k);
        if (k <= 4'd9)
            return {v[27:0], k};
        else if (k == 4'hB)
            return {4'h0, v[31:4]};
        else if (k == 4'hC)
            return 32'h0;
        else
            return v;
    endfunction

    logic [3:0]    col_m;
    logic [3:0]    col_s;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    r_cur;
    logic [1:0]    r_nxt;
    logic          sample;
    logic          frame_end;

    logic [3:0]    pressed;
    logic [2:0]    row_cnt;
    logic [1:0]    col_idx;
    logic [1:0]    acc_hits;
    logic [3:0]    acc_code;
    logic [1:0]    tot_hits;
    logic [3:0]    tot_code;
    logic          frame_hit;

    state_t        state;
    logic [2:0]    fc;
    logic [3:0]    cand;

    always_ff @(posedge cclk or negedge rst) begin
        if (!rst) begin
            col_m <= 4'hF;
            col_s <= 4'hF;
        end else begin
            col_m <= col;
            col_s <= col_m;
        end
    end

    assign cnt_nxt   = cnt + CW'(1);
    assign r_cur     = cnt[CW-1 -: 2];
    assign r_nxt     = cnt_nxt[CW-1 -: 2];
    assign sample    = &cnt[SCAN_BITS-1:0];
    assign frame_end = sample && (r_cur == 2'd3);

    // Row is computed from the next count so the driven row always matches r_cur.
    always_ff @(posedge cclk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            row <= 4'b1110;
        end else begin
            cnt <= cnt_nxt;
            row <= ~(4'b0001 << r_nxt);
        end
    end

    assign pressed = ~col_s;
    assign row_cnt = 3'($countones(pressed));

    always_comb begin
        col_idx = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (pressed[c])
                col_idx = 2'(c);
        end
    end

    // Contact count saturates at 2: anything beyond one contact is ghosting.
    always_comb begin
        tot_code = acc_code;
        if (row_cnt >= 3'd2 || acc_hits >= 2'd2 || (row_cnt == 3'd1 && acc_hits == 2'd1))
            tot_hits = 2'd2;
        else
            tot_hits = acc_hits + row_cnt[1:0];
        if (row_cnt == 3'd1)
            tot_code = {r_cur, col_idx};
    end

    assign frame_hit = (tot_hits == 2'd1);

    always_ff @(posedge cclk or negedge rst) begin
        if (!rst) begin
            acc_hits <= 2'd0;
            acc_code <= 4'd0;
        end else if (sample) begin
            if (r_cur == 2'd3) begin
                acc_hits <= 2'd0;
                acc_code <= 4'd0;
            end else begin
                acc_hits <= tot_hits;
                acc_code <= tot_code;
            end
        end
    end

    always_ff @(posedge cclk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fc        <= 3'd0;
            cand      <= 4'd0;
            key       <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            val       <= 32'h0;
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                case (state)
                    IDLE: begin
                        if (frame_hit) begin
                            cand <= tot_code;
                            fc   <= 3'd1;
                            if (DB == 3'd1) begin
                                key       <= tot_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                val       <= entry_next(val, tot_code);
                                state     <= HELD;
                            end else begin
                                state <= CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (frame_hit && tot_code == cand) begin
                            if (fc + 3'd1 >= DB) begin
                                key       <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                val       <= entry_next(val, cand);
                                fc        <= 3'd0;
                                state     <= HELD;
                            end else begin
                                fc <= fc + 3'd1;
                            end
                        end else begin
                            fc    <= 3'd0;
                            state <= IDLE;
                        end
                    end
                    HELD: begin
                        if (!frame_hit) begin
                            if (DB == 3'd1) begin
                                key_held <= 1'b0;
                                fc       <= 3'd0;
                                state    <= IDLE;
                            end else begin
                                fc    <= 3'd1;
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (frame_hit) begin
                            fc    <= 3'd0;
                            state <= HELD;
                        end else if (fc + 3'd1 >= DB) begin
                            key_held <= 1'b0;
                            fc       <= 3'd0;
                            state    <= IDLE;
                        end else begin
                            fc <= fc + 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad contact model, frame-level reference model checked every
// cycle, an entry-value table, and directed bounce/ghost/reset sequences.
module tb_keypad_scan;

    localparam int SB  = 2;
    localparam int D   = 2;
    localparam int DW  = 1 << SB;
    localparam int FR  = 4 * DW;

    logic        cclk;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;
    logic [31:0] val;

    logic [15:0] pressed;

    int n_cmp;
    int n_bad;
    int pulses;

    // reference model state
    int          m_n;
    logic [3:0]  m_row;
    logic [15:0] h0, h1, h2;
    int          m_hits;
    int          m_code;
    bit          m_held;
    int          m_run;
    int          m_nrun;
    int          m_cand;
    logic [3:0]  m_key;
    logic        m_valid;
    logic [31:0] m_val;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] exp_val;
    } entry_t;
    entry_t tbl[13];

    keypad_scan #(.SCAN_BITS(SB), .DEBOUNCE(D)) dut (
        .cclk      (cclk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held),
        .val       (val)
    );

    initial begin
        cclk = 1'b0;
        forever #5 cclk = ~cclk;
    end

    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4*r+c] && !row[r])
                    col[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, m_n);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_row = 4'b1110;
        h0 = '0; h1 = '0; h2 = '0;
        m_hits = 0; m_code = 0;
        m_held = 0; m_run = 0; m_nrun = 0; m_cand = 0;
        m_key = 4'd0; m_valid = 1'b0; m_val = 32'h0;
    endtask

    task automatic debounce(input int fk);
        if (!m_held) begin
            if (fk < 0 || (m_run > 0 && fk != m_cand)) begin
                m_run = 0;
            end else begin
                m_cand = fk;
                m_run++;
            end
            if (m_run == D) begin
                m_key   = 4'(m_cand);
                m_valid = 1'b1;
                m_held  = 1;
                m_run   = 0;
                m_nrun  = 0;
                if (m_cand <= 9)
                    m_val = (m_val << 4) | 32'(m_cand);
                else if (m_cand == 11)
                    m_val = m_val >> 4;
                else if (m_cand == 12)
                    m_val = 32'h0;
            end
        end else begin
            if (fk < 0) m_nrun++;
            else        m_nrun = 0;
            if (m_nrun == D) begin
                m_held = 0;
                m_nrun = 0;
            end
        end
    endtask

    // Columns seen at a row's last cycle are those driven two cycles earlier.
    task automatic model_step();
        int r;
        int fk;
        h2 = h1; h1 = h0; h0 = pressed;
        m_valid = 1'b0;
        if (m_n % DW == DW - 1) begin
            r = (m_n / DW) % 4;
            for (int c = 0; c < 4; c++)
                if (h2[4*r+c]) begin
                    m_hits++;
                    m_code = 4*r + c;
                end
            if (m_n % FR == FR - 1) begin
                fk = (m_hits == 1) ? m_code : -1;
                m_hits = 0;
                debounce(fk);
            end
        end
        m_n++;
        m_row = ~(4'(1) << ((m_n / DW) % 4));
    endtask

    task automatic tick();
        model_step();
        @(posedge cclk);
        #1;
        check("row", 32'(row), 32'(m_row));
        check("key_valid", 32'(key_valid), 32'(m_valid));
        check("key_held", 32'(key_held), 32'(m_held));
        check("key", 32'(key), 32'(m_key));
        check("val", val, m_val);
        if (key_valid) pulses++;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_row"}, 32'(row), 32'h0000000E);
        check({tag, "_valid"}, 32'(key_valid), 32'h0);
        check({tag, "_held"}, 32'(key_held), 32'h0);
        check({tag, "_key"}, 32'(key), 32'h0);
        check({tag, "_val"}, val, 32'h0);
    endtask

    task automatic do_reset(input int cyc);
        rst = 1'b0;
        #1;
        check_reset_vals("rst_async");
        repeat (cyc) @(posedge cclk);
        #1;
        check_reset_vals("rst_hold");
        rst = 1'b1;
        model_reset();
    endtask

    task automatic wait_pulse(input string name, input int budget);
        int start;
        bit got;
        start = pulses;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (pulses > start) begin
                got = 1;
                break;
            end
        end
        check({name, "_pulse"}, 32'(got), 32'h1);
    endtask

    task automatic wait_release(input string name, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!key_held) begin
                done = 1;
                break;
            end
        end
        check({name, "_released"}, 32'(done), 32'h1);
    endtask

    task automatic align_frame();
        while (m_n % FR != 0) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int pulse_at;
        int dur;
        int k1;
        int k2;
        n_cmp = 0; n_bad = 0; pulses = 0;
        pressed = '0;
        rst = 1'b0;
        model_reset();

        tbl[0]  = '{4'h1, 32'h00000001};
        tbl[1]  = '{4'h2, 32'h00000012};
        tbl[2]  = '{4'h3, 32'h00000123};
        tbl[3]  = '{4'h4, 32'h00001234};
        tbl[4]  = '{4'h5, 32'h00012345};
        tbl[5]  = '{4'h6, 32'h00123456};
        tbl[6]  = '{4'h7, 32'h01234567};
        tbl[7]  = '{4'h8, 32'h12345678};
        tbl[8]  = '{4'h9, 32'h23456789};
        tbl[9]  = '{4'hB, 32'h02345678};
        tbl[10] = '{4'hC, 32'h00000000};
        tbl[11] = '{4'hA, 32'h00000000};
        tbl[12] = '{4'h0, 32'h00000000};

        // reset and row rotation
        @(posedge cclk);
        #1;
        do_reset(3);
        ticks(2 * FR);

        // single press of key 5
        pressed = 16'(1) << 5;
        p0 = pulses;
        wait_pulse("press5", 6 * FR);
        check("press5_key", 32'(key), 32'h5);
        check("press5_val", val, 32'h00000005);
        check("press5_held", 32'(key_held), 32'h1);
        ticks(3 * FR);
        check("press5_one_pulse", 32'(pulses - p0), 32'h1);
        pressed = '0;
        wait_release("press5", 6 * FR);

        // bounce on key 7, toggled every 5 cycles for three frames, then held
        ticks(FR);
        align_frame();
        p0 = pulses;
        for (int i = 0; i < 3 * FR; i++) begin
            pressed = ((i / 5) % 2 == 0) ? (16'(1) << 7) : 16'h0;
            tick();
        end
        check("bounce_no_pulse", 32'(pulses - p0), 32'h0);
        pressed = 16'(1) << 7;
        wait_pulse("bounce7", 6 * FR);
        check("bounce7_key", 32'(key), 32'h7);
        check("bounce7_val", val, 32'h00000057);
        pressed = '0;
        wait_release("bounce7", 6 * FR);

        // ghosting: keys 1 and 6 together, then 6 released
        ticks(FR);
        p0 = pulses;
        pressed = (16'(1) << 1) | (16'(1) << 6);
        ticks(5 * FR);
        check("ghost_no_pulse", 32'(pulses - p0), 32'h0);
        check("ghost_val", val, 32'h00000057);
        pressed = 16'(1) << 1;
        wait_pulse("ghost1", 6 * FR);
        check("ghost1_key", 32'(key), 32'h1);
        check("ghost1_val", val, 32'h00000571);
        pressed = '0;
        wait_release("ghost1", 6 * FR);

        // entry, wrap, backspace, clear, ignored code
        do_reset(2);
        for (int i = 0; i < 13; i++) begin
            ticks(FR / 2);
            pressed = 16'(1) << tbl[i].code;
            wait_pulse($sformatf("entry%0d", i), 6 * FR);
            check($sformatf("entry%0d_key", i), 32'(key), 32'(tbl[i].code));
            check($sformatf("entry%0d_val", i), val, tbl[i].exp_val);
            pressed = '0;
            wait_release($sformatf("entry%0d", i), 6 * FR);
        end

        // reset while confirming, key kept down across reset
        ticks(FR);
        align_frame();
        pressed = 16'(1) << 3;
        ticks(FR + 4);
        check("midpress_no_pulse_yet", 32'(key_valid), 32'h0);
        p0 = pulses;
        do_reset(5);
        pulse_at = -1;
        for (int i = 0; i < 6 * FR; i++) begin
            tick();
            if (key_valid && pulse_at < 0) pulse_at = m_n;
        end
        check("midpress_pulse_cycle", 32'(pulse_at), 32'(2 * FR));
        check("midpress_one_pulse", 32'(pulses - p0), 32'h1);
        check("midpress_key", 32'(key), 32'h3);
        pressed = '0;
        wait_release("midpress", 6 * FR);

        // randomized presses, ghosts and bounces against the model
        for (int it = 0; it < 30; it++) begin
            k1 = $urandom_range(0, 15);
            k2 = $urandom_range(0, 15);
            dur = $urandom_range(FR, 5 * FR);
            case ($urandom_range(0, 3))
                0: begin
                    pressed = 16'(1) << k1;
                    ticks(dur);
                end
                1: begin
                    pressed = (16'(1) << k1) | (16'(1) << k2);
                    ticks(dur);
                end
                2: begin
                    for (int i = 0; i < dur; i++) begin
                        pressed = ($urandom_range(0, 2) != 0) ? (16'(1) << k1) : 16'h0;
                        tick();
                    end
                end
                default: begin
                    pressed = '0;
                    ticks(dur);
                end
            endcase
            pressed = '0;
            ticks($urandom_range(4, 4 * FR));
        end
        ticks(4 * FR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 matrix keypad and turns debounced key presses into hex key codes and an 8-nibble entry value. It is the input-side counterpart of the multiplexed 7-segment display driver.
- It drives one keypad row at a time, the way the display driver strobes one digit at a time.
- Its `val` output uses the same packing the display consumes (nibble 0 = rightmost digit), so clock-setting entries can be shown directly.

## Interface
- `SCAN_BITS`, default 15: log2 of the row dwell in `cclk` cycles. Must be ≥ 2. One full frame is 4·2^SCAN_BITS cycles.
- `DEBOUNCE`, default 3: number of consecutive identical frames needed to accept a press or a release. Range 1–7.

Ports:
- `cclk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low; one clock, no other reset.
- `row`  out  4  row drive, active-low one-hot; row r is driven when `row[r]`=0.
- `col`  in  4  column sense, active-low (external pull-ups); asynchronous to `cclk`.
- `key`  out  4  code of the last accepted key.
- `key_valid`  out  1  one-cycle pulse when a press is accepted.
- `key_held`  out  1  high from acceptance until the release is accepted.
- `val`  out  32  entry register; nibble n = digit n, nibble 0 is the newest digit.

## Operation
- **Column synchronizer:** `col` passes through a 2-flop synchronizer; only the synchronized value is used.
- **Scan counter:** free-running, SCAN_BITS+2 bits wide, wraps.
  - The top 2 bits are the row index r.
  - `row` = ~(4'b0001 << r), registered.
- **Column sampling:** synchronized columns are sampled on the last cycle of each row dwell (low SCAN_BITS bits all ones). This gives ≥ 2 cycles of settling after a row change.
- **Frame result:** evaluated at the row-3 sample (end of frame).
  - Exactly one pressed contact in the frame → frame key = 4·r + c, where c is the column index of the low `col` bit.
  - Zero contacts → NONE.
  - Two or more contacts, in one row or across rows → NONE (ghosting rejection).
- **FSM states:** IDLE, CONFIRM, HELD, RELEASE. A 3-bit frame counter `fc` is used by CONFIRM and RELEASE.
  - **IDLE:** frame key K → latch candidate K, `fc`=1. If DEBOUNCE=1, accept immediately; otherwise go to CONFIRM. NONE → stay in IDLE.
  - **CONFIRM:** frame key == candidate → `fc`++.
    - When `fc` reaches DEBOUNCE: accept, which sets `key`=candidate, pulses `key_valid`, and enters HELD.
    - Different key or NONE → IDLE, with no output.
  - **HELD:** `key_held`=1. A NONE frame → RELEASE with `fc`=1, or directly to IDLE if DEBOUNCE=1. Any key frame → stay in HELD; there is no auto-repeat, and a second key is ignored until release.
  - **RELEASE:** NONE → `fc`++; at DEBOUNCE → IDLE and `key_held`=0. Any key frame → back to HELD.
- **Entry register:** updated in the same cycle `key_valid` is asserted.
  - Codes 0–9: `val` ← {val[27:0], code}. The oldest nibble is discarded; this is the wrap at 8 digits.
  - Code 0xB (backspace): `val` ← {4'h0, val[31:4]}.
  - Code 0xC (clear): `val` ← 0.
  - Codes 0xA and 0xD–0xF: `val` unchanged; `key_valid` still pulses.

## Timing
- **Reset values:** scan counter 0, `row`=4'b1110, synchronizer 4'hF, `key`=0, `key_valid`=0, `key_held`=0, `val`=0, FSM=IDLE, `fc`=0.
- **Reset mid-press:** the press is discarded. After release of `rst`, the key needs DEBOUNCE full frames from the first complete frame.
- **Reset mid-frame:** the partial frame is lost.
- **Press latency:** `key_valid` rises one cycle after the end-of-frame sample of the DEBOUNCE-th matching frame. This is at most (DEBOUNCE+1) frames + 3 cycles after `col` goes stable.
- **`key_held` fall:** one cycle after the end-of-frame sample of the DEBOUNCE-th NONE frame.
- **Pulse spacing:** `key_valid` is high for exactly 1 cycle. Two pulses are at least 2·DEBOUNCE frames apart.
- **Outputs:** all are registered; there is no combinational path from `col` to any output.

## Test plan
Bench uses SCAN_BITS=2 and DEBOUNCE=2, giving 16-cycle frames.
- **Reset:** hold `rst`=0 → `row`=1110, `val`=0, `key_valid`=0. Release → row rotates 1110, 1101, 1011, 0111, each for 4 cycles, then wraps.
- **Single press:** key 5 (row 1, col 1) held steady → exactly one `key_valid` pulse with `key`=5, `val`=32'h00000005, `key_held`=1.
- **Release:** after release, `key_held` falls after 2 NONE frames.
- **Bounce:** key 7 toggled every 5 cycles for 3 frames, then held → no pulse during the bounce, then a single pulse for 7.
- **Ghosting:** keys 1 and 6 pressed together → no `key_valid`, `val` unchanged. Release key 6 → a pulse for 1.
- **Entry and wrap:** press 1,2,3,4,5,6,7,8,9 → `val`=32'h23456789. Then 0xB → 32'h02345678. Then 0xC → 0. Then 0xA → pulse with `val` unchanged.
- **Reset mid-press:** assert `rst` during CONFIRM → no pulse. Deassert with the key still held → pulse only after 2 fresh full frames.
